seq_pattern_tx: RTL and testbench

//  Serial pattern transmitter: the drive side of the serial sequence-detector blocks.

---
 rtl/seq_pattern_tx_pkg.sv | 20 ++
 rtl/seq_tx_shifter.sv | 60 ++++++
 rtl/seq_pattern_tx.sv | 136 +++++++++++++
 tb/tb_seq_pattern_tx.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/seq_pattern_tx_pkg.sv
// Shared definitions for the serial pattern transmitter and the detectors it drives:
// FSM state encoding, default frame pattern and a counter-width helper.
package seq_pattern_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } tx_state_e;

    localparam int         DEFAULT_WIDTH   = 4;
    localparam logic [3:0] DEFAULT_PATTERN = 4'b1011;

    // Bits needed to hold values 0..n-1, never less than one.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seq_tx_shifter.sv
// Frame shift register for seq_pattern_tx: keeps the accepted word for repeats,
// shifts it MSB-first and counts down the bit index of the current frame.
module seq_tx_shifter
    import seq_pattern_tx_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load_i,
    input  logic             reload_i,
    input  logic             shift_i,
    input  logic [WIDTH-1:0] din_i,
    output logic             msb_o,
    output logic             next_msb_o,
    output logic             word_msb_o,
    output logic             last_bit_o
);

    localparam int IW = cnt_w(WIDTH);

    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic [IW-1:0]    idx_q, idx_d;

    always_comb begin
        shreg_d = shreg_q;
        word_d  = word_q;
        idx_d   = idx_q;
        if (load_i) begin
            shreg_d = din_i;
            word_d  = din_i;
            idx_d   = IW'(WIDTH - 1);
        end else if (reload_i) begin
            shreg_d = word_q;
            idx_d   = IW'(WIDTH - 1);
        end else if (shift_i) begin
            shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
            idx_d   = idx_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shreg_q <= '0;
            word_q  <= '0;
            idx_q   <= '0;
        end else begin
            shreg_q <= shreg_d;
            word_q  <= word_d;
            idx_q   <= idx_d;
        end
    end

    assign msb_o      = shreg_q[WIDTH-1];
    assign next_msb_o = shreg_q[WIDTH-2];
    assign word_msb_o = word_q[WIDTH-1];
    assign last_bit_o = (idx_q == '0);

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: accepts a word on a valid/ready handshake and sends it
// MSB-first repeat_cnt+1 times, with GAP idle cycles between frames.
module seq_pattern_tx
    import seq_pattern_tx_pkg::*;
#(
    parameter int               WIDTH   = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] PATTERN = WIDTH'(DEFAULT_PATTERN),
    parameter int               RPT_W   = 4,
    parameter int               GAP     = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] data_in,
    input  logic             use_default,
    input  logic [RPT_W-1:0] repeat_cnt,
    input  logic             abort,
    output logic             x,
    output logic             x_valid,
    output logic             busy,
    output logic             done
);

    localparam int            GW       = cnt_w(GAP);
    localparam logic [GW-1:0] GAP_LOAD = GW'((GAP > 0) ? GAP - 1 : 0);

    tx_state_e        state_q;
    logic [RPT_W-1:0] reps_left_q;
    logic [GW-1:0]    gap_cnt_q;
    logic             x_q, x_valid_q, busy_q, done_q, start_ready_q;

    logic             hs;
    logic [WIDTH-1:0] load_word;
    logic             sh_msb, sh_next_msb, sh_word_msb, sh_last;
    logic             sh_shift, sh_reload;

    assign hs        = start_valid & start_ready_q;
    assign load_word = use_default ? PATTERN : data_in;
    assign sh_shift  = (state_q == ST_SEND) && !sh_last && !abort;
    assign sh_reload = (state_q == ST_SEND) && sh_last && (reps_left_q != '0) && !abort;

    seq_tx_shifter #(
        .WIDTH(WIDTH)
    ) u_shifter (
        .clk        (clk),
        .reset_n    (reset_n),
        .load_i     (hs),
        .reload_i   (sh_reload),
        .shift_i    (sh_shift),
        .din_i      (load_word),
        .msb_o      (sh_msb),
        .next_msb_o (sh_next_msb),
        .word_msb_o (sh_word_msb),
        .last_bit_o (sh_last)
    );

    // Outputs are registered alongside the state, so x carries next cycle's bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            reps_left_q   <= '0;
            gap_cnt_q     <= '0;
            x_q           <= 1'b0;
            x_valid_q     <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            start_ready_q <= 1'b1;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (hs) begin
                        state_q       <= ST_SEND;
                        reps_left_q   <= repeat_cnt;
                        x_q           <= load_word[WIDTH-1];
                        x_valid_q     <= 1'b1;
                        busy_q        <= 1'b1;
                        start_ready_q <= 1'b0;
                    end
                end
                ST_SEND: begin
                    if (abort) begin
                        state_q       <= ST_IDLE;
                        x_q           <= 1'b0;
                        x_valid_q     <= 1'b0;
                        busy_q        <= 1'b0;
                        start_ready_q <= 1'b1;
                    end else if (!sh_last) begin
                        x_q <= sh_next_msb;
                    end else if (reps_left_q == '0) begin
                        state_q   <= ST_DONE;
                        x_q       <= 1'b0;
                        x_valid_q <= 1'b0;
                        done_q    <= 1'b1;
                    end else begin
                        reps_left_q <= reps_left_q - 1'b1;
                        if (GAP > 0) begin
                            state_q   <= ST_GAP;
                            gap_cnt_q <= GAP_LOAD;
                            x_q       <= 1'b0;
                            x_valid_q <= 1'b0;
                        end else begin
                            x_q <= sh_word_msb;
                        end
                    end
                end
                ST_GAP: begin
                    if (abort) begin
                        state_q       <= ST_IDLE;
                        busy_q        <= 1'b0;
                        start_ready_q <= 1'b1;
                    end else if (gap_cnt_q == '0) begin
                        state_q   <= ST_SEND;
                        x_q       <= sh_msb;
                        x_valid_q <= 1'b1;
                    end else begin
                        gap_cnt_q <= gap_cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q       <= ST_IDLE;
                    busy_q        <= 1'b0;
                    start_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign start_ready = start_ready_q;
    assign x           = x_q;
    assign x_valid     = x_valid_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Bench for seq_pattern_tx: a back-to-back instance and a GAP=2 instance share stimulus,
// each compared every cycle against a burst-queue model of the expected output stream.
module tb_seq_pattern_tx;

    typedef struct packed {
        logic ready;
        logic busy;
        logic done;
        logic xv;
        logic x;
    } exp_t;
    typedef exp_t exp_q_t[$];

    logic       clk;
    logic       reset_n;
    logic       start_valid;
    logic [3:0] data_in;
    logic       use_default;
    logic [3:0] repeat_cnt;
    logic       abort;

    logic a_ready, a_x, a_xv, a_busy, a_done;
    logic b_ready, b_x, b_xv, b_busy, b_done;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    exp_q_t q_a, q_b;
    exp_t   cur_a, cur_b, e_idle;

    logic [3:0] det_hist;
    int         det_bits, det_cnt, xv_cnt;

    seq_pattern_tx #(.WIDTH(4), .PATTERN(4'b1011), .RPT_W(4), .GAP(0)) dut_a (
        .clk(clk), .reset_n(reset_n), .start_valid(start_valid), .start_ready(a_ready),
        .data_in(data_in), .use_default(use_default), .repeat_cnt(repeat_cnt), .abort(abort),
        .x(a_x), .x_valid(a_xv), .busy(a_busy), .done(a_done)
    );

    seq_pattern_tx #(.WIDTH(4), .PATTERN(4'b1011), .RPT_W(4), .GAP(2)) dut_b (
        .clk(clk), .reset_n(reset_n), .start_valid(start_valid), .start_ready(b_ready),
        .data_in(data_in), .use_default(use_default), .repeat_cnt(repeat_cnt), .abort(abort),
        .x(b_x), .x_valid(b_xv), .busy(b_busy), .done(b_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
    endtask

    // Whole expected output stream of one burst, one entry per cycle after the handshake.
    function automatic exp_q_t build(input logic [3:0] w, input int frames, input int gap);
        exp_q_t q;
        exp_t   e;
        for (int f = 0; f < frames; f++) begin
            for (int b = 3; b >= 0; b--) begin
                e = '0; e.busy = 1'b1; e.xv = 1'b1; e.x = w[b];
                q.push_back(e);
            end
            if (f < frames - 1) begin
                for (int g = 0; g < gap; g++) begin
                    e = '0; e.busy = 1'b1;
                    q.push_back(e);
                end
            end
        end
        e = '0; e.busy = 1'b1; e.done = 1'b1;
        q.push_back(e);
        return q;
    endfunction

    task automatic step(inout exp_q_t q, inout exp_t cur, input int gap);
        logic [3:0] w;
        if (!cur.busy) begin
            if (start_valid) begin
                w   = use_default ? 4'b1011 : data_in;
                q   = build(w, int'(repeat_cnt) + 1, gap);
                cur = q.pop_front();
            end
        end else if (abort && !cur.done) begin
            q.delete();
            cur = e_idle;
        end else if (q.size() > 0) begin
            cur = q.pop_front();
        end else begin
            cur = e_idle;
        end
    endtask

    task automatic compare_all(input string sfx);
        chk({"outA", sfx}, {27'd0, a_ready, a_busy, a_done, a_xv, a_x}, {27'd0, cur_a});
        chk({"outB", sfx}, {27'd0, b_ready, b_busy, b_done, b_xv, b_x}, {27'd0, cur_b});
    endtask

    task automatic cycle(input logic sv, input logic [3:0] din, input logic ud,
                         input logic [3:0] rc, input logic ab, input logic rn);
        @(negedge clk);
        cyc++;
        compare_all("");
        if (a_xv) begin
            xv_cnt++;
            det_hist = {det_hist[2:0], a_x};
            det_bits++;
            if (det_bits >= 4 && det_hist == 4'b1011) det_cnt++;
        end
        start_valid = sv; data_in = din; use_default = ud;
        repeat_cnt = rc; abort = ab; reset_n = rn;
        if (!rn) begin
            q_a.delete(); q_b.delete();
            cur_a = e_idle; cur_b = e_idle;
            #1 compare_all("_rst");
        end else begin
            step(q_a, cur_a, 0);
            step(q_b, cur_b, 2);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b0, 4'($urandom), 1'b0, 4'($urandom), 1'b0, 1'b1);
    endtask

    task automatic det_clear();
        det_hist = '0; det_bits = 0; det_cnt = 0; xv_cnt = 0;
    endtask

    initial begin
        e_idle = '0; e_idle.ready = 1'b1;
        cur_a = e_idle; cur_b = e_idle;
        det_clear();
        start_valid = 0; data_in = 0; use_default = 0; repeat_cnt = 0; abort = 0;
        reset_n = 1'b1;
        #2 reset_n = 1'b0;
        repeat (2) cycle(1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0);
        idle(2);

        // default pattern, single frame
        cycle(1'b1, 4'h0, 1'b1, 4'd0, 1'b0, 1'b1);
        idle(8);

        // three frames of data_in, loopback through a 1011 detector
        det_clear();
        cycle(1'b1, 4'b1011, 1'b0, 4'd2, 1'b0, 1'b1);
        idle(22);
        chk("loopback_z", det_cnt, 3);
        chk("loopback_bits", xv_cnt, 12);

        // two frames (gap visible on instance B)
        cycle(1'b1, 4'b1011, 1'b0, 4'd1, 1'b0, 1'b1);
        idle(16);

        // abort during bit 2 of frame 1, then a new start
        cycle(1'b1, 4'b1100, 1'b0, 4'd2, 1'b0, 1'b1);
        cycle(1'b0, 4'h0, 1'b0, 4'd0, 1'b0, 1'b1);
        cycle(1'b0, 4'h0, 1'b0, 4'd0, 1'b1, 1'b1);
        idle(3);
        cycle(1'b1, 4'b0110, 1'b0, 4'd0, 1'b0, 1'b1);
        idle(8);

        // start and abort together in IDLE: start wins
        cycle(1'b1, 4'b1001, 1'b0, 4'd1, 1'b1, 1'b1);
        idle(16);

        // start pulsed while busy, then reset mid-send
        cycle(1'b1, 4'b1110, 1'b0, 4'd3, 1'b0, 1'b1);
        cycle(1'b0, 4'h0, 1'b0, 4'd0, 1'b0, 1'b1);
        cycle(1'b1, 4'b0001, 1'b1, 4'd0, 1'b0, 1'b1);
        cycle(1'b0, 4'h0, 1'b0, 4'd0, 1'b0, 1'b1);
        cycle(1'b0, 4'h0, 1'b0, 4'd0, 1'b0, 1'b0);
        idle(3);

        // maximum repeat count: 16 frames
        det_clear();
        cycle(1'b1, 4'h0, 1'b1, 4'd15, 1'b0, 1'b1);
        idle(70);
        chk("max_rpt_bits", xv_cnt, 64);
        idle(40);

        // randomized traffic
        for (int i = 0; i < 2500; i++) begin
            cycle(($urandom_range(0, 3) == 0),
                  4'($urandom),
                  ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 9) == 0) ? 4'd15 : 4'($urandom_range(0, 3)),
                  ($urandom_range(0, 29) == 0),
                  ($urandom_range(0, 299) != 0));
        end
        idle(120);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
